// File: rtl/pmem_port_arbiter.sv
// Round-robin arbiter sharing one program-memory RAM port between the CPU (r0) and
// the debug/loader path (r1). It also contains a fill sequencer that writes INIT_VALUE everywhere.
module pmem_port_arbiter #(
  parameter int          ADDR_MSB   = 11,
  parameter logic [15:0] INIT_VALUE = 16'h0000
) (
  input  logic              mclk,
  input  logic              puc_rst,

  input  logic              r0_req,
  input  logic [1:0]        r0_we,
  input  logic [ADDR_MSB:0] r0_addr,
  input  logic [15:0]       r0_din,
  output logic              r0_gnt,
  output logic              r0_rvalid,

  input  logic              r1_req,
  input  logic [1:0]        r1_we,
  input  logic [ADDR_MSB:0] r1_addr,
  input  logic [15:0]       r1_din,
  output logic              r1_gnt,
  output logic              r1_rvalid,

  output logic [15:0]       rdata,

  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,

  output logic              ram_en,
  output logic [1:0]        ram_we,
  output logic [ADDR_MSB:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam logic [ADDR_MSB:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_MSB:0] cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              r0_rvalid_q, r0_rvalid_d;
  logic              r1_rvalid_q, r1_rvalid_d;
  logic [ADDR_MSB:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic              en_d;
  logic [1:0]        we_d;
  logic              arb_en;
  logic              gnt0, gnt1;

  // Fill sequencer: init_start is only looked at in IDLE, so pulses during a fill are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A starting fill takes the port in the same cycle, so requests are not served then.
  always_comb begin
    arb_en = 1'b0;
    if (!puc_rst) begin
      arb_en = ((state_q == IDLE) && !init_start) || (state_q == DONE);
    end
    // The pointer holds the last winner, so on a tie the other requester is served.
    gnt0 = arb_en && r0_req && (!r1_req || ptr_q);
    gnt1 = arb_en && r1_req && (!r0_req || !ptr_q);
  end

  always_comb begin
    en_d        = 1'b0;
    we_d        = 2'b00;
    addr_d      = addr_q;
    din_d       = din_q;
    ptr_d       = ptr_q;
    r0_rvalid_d = gnt0 && (r0_we == 2'b00);
    r1_rvalid_d = gnt1 && (r1_we == 2'b00);
    if (!puc_rst) begin
      if (state_q == INIT) begin
        en_d   = 1'b1;
        we_d   = 2'b11;
        addr_d = cnt_q;
        din_d  = INIT_VALUE;
      end else if (gnt0) begin
        en_d   = 1'b1;
        we_d   = r0_we;
        addr_d = r0_addr;
        din_d  = r0_din;
        ptr_d  = 1'b0;
      end else if (gnt1) begin
        en_d   = 1'b1;
        we_d   = r1_we;
        addr_d = r1_addr;
        din_d  = r1_din;
        ptr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b1;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
    end
  end

  // Address/data only hold the last value driven when the port is idle; no reset needed.
  always_ff @(posedge mclk) begin
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign rdata     = ram_dout;
  assign init_busy = (state_q == INIT);
  assign init_done = (state_q == DONE);
  assign ram_en    = en_d;
  assign ram_we    = we_d;
  assign ram_addr  = addr_d;
  assign ram_din   = din_d;

endmodule

// File: tb/tb_pmem_port_arbiter.sv
// Directed bench for pmem_port_arbiter: instance A (full-size) covers reads, byte writes and contention,
// instance B (16 words, INIT_VALUE 5A5A) covers the fill sequencer, mid-fill reset and ignored restart.
module tb_pmem_port_arbiter;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic puc_rst;

  logic        a_r0_req, a_r1_req, a_r0_gnt, a_r1_gnt, a_r0_rvalid, a_r1_rvalid;
  logic [1:0]  a_r0_we, a_r1_we, a_ram_we;
  logic [11:0] a_r0_addr, a_r1_addr, a_ram_addr;
  logic [15:0] a_r0_din, a_r1_din, a_rdata, a_ram_din, a_ram_dout;
  logic        a_init_start, a_init_busy, a_init_done, a_ram_en;

  logic        b_r0_req, b_r1_req, b_r0_gnt, b_r1_gnt, b_r0_rvalid, b_r1_rvalid;
  logic [1:0]  b_r0_we, b_r1_we, b_ram_we;
  logic [3:0]  b_r0_addr, b_r1_addr, b_ram_addr;
  logic [15:0] b_r0_din, b_r1_din, b_rdata, b_ram_din, b_ram_dout;
  logic        b_init_start, b_init_busy, b_init_done, b_ram_en;

  pmem_port_arbiter dut_a (
    .mclk(mclk), .puc_rst(puc_rst),
    .r0_req(a_r0_req), .r0_we(a_r0_we), .r0_addr(a_r0_addr), .r0_din(a_r0_din),
    .r0_gnt(a_r0_gnt), .r0_rvalid(a_r0_rvalid),
    .r1_req(a_r1_req), .r1_we(a_r1_we), .r1_addr(a_r1_addr), .r1_din(a_r1_din),
    .r1_gnt(a_r1_gnt), .r1_rvalid(a_r1_rvalid),
    .rdata(a_rdata),
    .init_start(a_init_start), .init_busy(a_init_busy), .init_done(a_init_done),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_din(a_ram_din),
    .ram_dout(a_ram_dout)
  );

  pmem_port_arbiter #(.ADDR_MSB(3), .INIT_VALUE(16'h5A5A)) dut_b (
    .mclk(mclk), .puc_rst(puc_rst),
    .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_din(b_r0_din),
    .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid),
    .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_din(b_r1_din),
    .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid),
    .rdata(b_rdata),
    .init_start(b_init_start), .init_busy(b_init_busy), .init_done(b_init_done),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
    .ram_dout(b_ram_dout)
  );

  // Byte-writable RAM models with a registered read port
  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:15];
  int b_fills = 0;
  int b_dones = 0;

  always @(posedge mclk) begin
    if (a_ram_en) begin
      a_ram_dout <= mem_a[a_ram_addr];
      if (a_ram_we[1]) mem_a[a_ram_addr][15:8] <= a_ram_din[15:8];
      if (a_ram_we[0]) mem_a[a_ram_addr][7:0]  <= a_ram_din[7:0];
    end
  end

  always @(posedge mclk) begin
    if (b_ram_en) begin
      b_ram_dout <= mem_b[b_ram_addr];
      if (b_ram_we[1]) mem_b[b_ram_addr][15:8] <= b_ram_din[15:8];
      if (b_ram_we[0]) mem_b[b_ram_addr][7:0]  <= b_ram_din[7:0];
    end
    if (b_ram_en && (b_ram_we == 2'b11)) b_fills++;
    if (b_init_done) b_dones++;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge mclk);
    #2;
  endtask

  initial begin
    int f0;
    int d0;
    puc_rst = 1'b1;
    a_r0_req = 1'b1; a_r0_we = 2'b00; a_r0_addr = '0; a_r0_din = '0;
    a_r1_req = 1'b0; a_r1_we = 2'b00; a_r1_addr = '0; a_r1_din = '0;
    a_init_start = 1'b0;
    b_r0_req = 1'b0; b_r0_we = 2'b00; b_r0_addr = '0; b_r0_din = '0;
    b_r1_req = 1'b0; b_r1_we = 2'b00; b_r1_addr = '0; b_r1_din = '0;
    b_init_start = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_r0_gnt", 32'(a_r0_gnt), 0);
    chk("rst_ram_en", 32'(a_ram_en), 0);
    chk("rst_ram_we", 32'(a_ram_we), 0);
    chk("rst_r0_rvalid", 32'(a_r0_rvalid), 0);
    chk("rst_busy", 32'(a_init_busy), 0);
    chk("rst_done", 32'(a_init_done), 0);
    a_r0_req = 1'b0;
    puc_rst = 1'b0;

    // Preload 0x010 through r1
    a_r1_req = 1'b1; a_r1_we = 2'b11; a_r1_addr = 12'h010; a_r1_din = 16'hBEEF;
    #1;
    chk("wr_r1_gnt", 32'(a_r1_gnt), 1);
    chk("wr_ram_en", 32'(a_ram_en), 1);
    chk("wr_ram_we", 32'(a_ram_we), 3);
    chk("wr_ram_addr", 32'(a_ram_addr), 'h010);
    chk("wr_ram_din", 32'(a_ram_din), 'hBEEF);
    cyc();
    a_r1_req = 1'b0; a_r1_we = 2'b00;
    chk("wr_no_rvalid", 32'(a_r1_rvalid), 0);

    // Single read
    a_r0_req = 1'b1; a_r0_we = 2'b00; a_r0_addr = 12'h010;
    #1;
    chk("rd_r0_gnt", 32'(a_r0_gnt), 1);
    cyc();
    a_r0_req = 1'b0;
    chk("rd_r0_rvalid", 32'(a_r0_rvalid), 1);
    chk("rd_rdata", 32'(a_rdata), 'hBEEF);
    chk("rd_r1_rvalid", 32'(a_r1_rvalid), 0);
    #1;
    chk("idle_ram_en", 32'(a_ram_en), 0);
    chk("idle_ram_we", 32'(a_ram_we), 0);
    chk("idle_addr_hold", 32'(a_ram_addr), 'h010);

    // Byte write then read back
    a_r1_req = 1'b1; a_r1_we = 2'b11; a_r1_addr = 12'h020; a_r1_din = 16'h1234;
    cyc();
    a_r1_we = 2'b10; a_r1_din = 16'hAB00;
    #1;
    chk("bw_b2b_gnt", 32'(a_r1_gnt), 1);
    cyc();
    a_r1_req = 1'b0; a_r1_we = 2'b00;
    a_r0_req = 1'b1; a_r0_addr = 12'h020;
    cyc();
    a_r0_req = 1'b0;
    chk("bw_rvalid", 32'(a_r0_rvalid), 1);
    chk("bw_rdata", 32'(a_rdata), 'hAB34);

    // Contention from reset
    puc_rst = 1'b1;
    a_r0_req = 1'b1; a_r0_we = 2'b00; a_r0_addr = 12'h010;
    a_r1_req = 1'b1; a_r1_we = 2'b00; a_r1_addr = 12'h020;
    #1;
    chk("ct_rst_gnt0", 32'(a_r0_gnt), 0);
    chk("ct_rst_gnt1", 32'(a_r1_gnt), 0);
    cyc();
    chk("ct_rst_rvalid", 32'(a_r0_rvalid), 0);
    puc_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("ct_gnt0", 32'(a_r0_gnt), 32'(k % 2 == 0));
      chk("ct_gnt1", 32'(a_r1_gnt), 32'(k % 2 == 1));
      if (k > 0) begin
        chk("ct_rvalid0", 32'(a_r0_rvalid), 32'((k - 1) % 2 == 0));
        chk("ct_rvalid1", 32'(a_r1_rvalid), 32'((k - 1) % 2 == 1));
        chk("ct_rdata", 32'(a_rdata), ((k - 1) % 2 == 0) ? 'hBEEF : 'hAB34);
      end else begin
        chk("ct_first_rvalid", 32'(a_r0_rvalid | a_r1_rvalid), 0);
      end
      cyc();
    end
    a_r0_req = 1'b0; a_r1_req = 1'b0;

    // Fill on instance B, init_start competing with an r0 read
    f0 = b_fills;
    d0 = b_dones;
    b_r0_req = 1'b1; b_r0_we = 2'b00; b_r0_addr = 4'd3;
    b_init_start = 1'b1;
    #1;
    chk("fill_start_gnt", 32'(b_r0_gnt), 0);
    chk("fill_start_en", 32'(b_ram_en), 0);
    cyc();
    b_init_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_init_start = (i == 3);
      #1;
      chk("fill_busy", 32'(b_init_busy), 1);
      chk("fill_gnt", 32'(b_r0_gnt), 0);
      chk("fill_addr", 32'(b_ram_addr), i);
      chk("fill_we", 32'(b_ram_we), 3);
      chk("fill_din", 32'(b_ram_din), 'h5A5A);
      chk("fill_done", 32'(b_init_done), 0);
      cyc();
    end
    b_init_start = 1'b0;
    #1;
    chk("done_pulse", 32'(b_init_done), 1);
    chk("done_busy", 32'(b_init_busy), 0);
    chk("done_gnt", 32'(b_r0_gnt), 1);
    chk("done_addr", 32'(b_ram_addr), 3);
    cyc();
    b_r0_req = 1'b0;
    chk("done_rvalid", 32'(b_r0_rvalid), 1);
    chk("done_rdata", 32'(b_rdata), 'h5A5A);
    chk("done_cleared", 32'(b_init_done), 0);
    chk("fill_writes", 32'(b_fills - f0), 16);

    // Read back every word
    for (int i = 0; i < 16; i++) begin
      b_r0_req = 1'b1; b_r0_addr = 4'(i);
      cyc();
      chk("rb_rvalid", 32'(b_r0_rvalid), 1);
      chk("rb_rdata", 32'(b_rdata), 'h5A5A);
    end
    b_r0_req = 1'b0;
    cyc();
    chk("one_done", 32'(b_dones - d0), 1);

    // Reset at fill cycle 5
    d0 = b_dones;
    b_init_start = 1'b1;
    cyc();
    b_init_start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("mf_addr5", 32'(b_ram_addr), 5);
    puc_rst = 1'b1;
    b_r0_req = 1'b1; b_r0_we = 2'b00; b_r0_addr = 4'd7;
    #1;
    chk("mf_rst_gnt", 32'(b_r0_gnt), 0);
    chk("mf_rst_en", 32'(b_ram_en), 0);
    cyc();
    chk("mf_busy", 32'(b_init_busy), 0);
    chk("mf_done", 32'(b_init_done), 0);
    chk("mf_rst_gnt2", 32'(b_r0_gnt), 0);
    cyc();
    puc_rst = 1'b0;
    #1;
    chk("mf_rel_gnt", 32'(b_r0_gnt), 1);
    cyc();
    b_r0_req = 1'b0;
    chk("mf_rvalid", 32'(b_r0_rvalid), 1);
    cyc();
    cyc();
    chk("mf_no_done", 32'(b_dones - d0), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pmem_port_arbiter.md
Name: pmem_port_arbiter

Overview:
- Shares one port of the dual-port program memory between two requesters: requester 0 is the CPU fetch/data path and requester 1 is the debug/loader path.
- Grants are round-robin, with single-cycle grant and fixed one-cycle read latency.
- Contains an init sequencer that fills the whole memory with a constant on command, locking out both requesters while it runs.
- Sits between the requesters and the port-A pins (en, we[1:0], addr, din, dout) of the dual-port RAM wrapper; enables and write enables are active-high.

Parameters:
- ADDR_MSB, 11, MSB of word address; memory depth is 2^(ADDR_MSB+1) words.
- INIT_VALUE, 16'h0000, word written to every location by the init sequence.

Ports:
- mclk in 1: clock; all state updates on the rising edge.
- puc_rst in 1: synchronous, active-high reset.
- r0_req in 1: requester 0 access request.
- r0_we in 2: requester 0 byte write enable; [1] = high byte, [0] = low byte; 00 = read.
- r0_addr in ADDR_MSB+1: requester 0 word address.
- r0_din in 16: requester 0 write data.
- r0_gnt out 1: requester 0 access accepted this cycle.
- r0_rvalid out 1: rdata holds requester 0 read data.
- r1_req, r1_we, r1_addr, r1_din, r1_gnt, r1_rvalid: same as r0_* for requester 1.
- rdata out 16: shared read data, valid only when an rN_rvalid is high.
- init_start in 1: one-cycle pulse that starts a memory fill.
- init_busy out 1: fill in progress.
- init_done out 1: one-cycle pulse on fill completion.
- ram_en out 1: RAM port enable (active-high).
- ram_we out 2: RAM byte write enable (active-high).
- ram_addr out ADDR_MSB+1: RAM address.
- ram_din out 16: RAM write data.
- ram_dout in 16: RAM read data, registered inside the RAM, one cycle after en.

Behaviour:
- FSM states: IDLE, INIT, DONE. Reset state is IDLE.
- Reset values: init_busy=0, init_done=0, r0_rvalid=0, r1_rvalid=0, fill counter=0, last-grant pointer=1 (so requester 0 wins the first tie).
- While puc_rst=1: r0_gnt=0, r1_gnt=0, ram_en=0, ram_we=00.
- Arbitration is combinational and applies only in IDLE or DONE with puc_rst=0:
  - only rN_req high -> grant N;
  - both high -> grant the requester not equal to the pointer;
  - pointer updates to the granted index on every grant.
- When a grant is given: ram_en=1; ram_we/ram_addr/ram_din = granted requester's signals, passed through in the same cycle.
- When no grant is given: ram_en=0 and ram_we=00; ram_addr/ram_din hold their last driven value.
- Requesters hold req/we/addr/din stable until gnt. A requester may issue back-to-back requests on consecutive cycles.
- Read latency:
  - rN_rvalid is registered; it is 1 in cycle t+1 iff rN_gnt=1 and rN_we=00 in cycle t.
  - rdata = ram_dout, passed through combinationally.
  - Writes never raise rvalid.
- Byte writes: we=10 writes bits[15:8] only; we=01 writes bits[7:0] only; we=11 writes the full word.
- init_start:
  - Sampled only in IDLE. In INIT or DONE it is ignored, with no queuing.
  - IDLE + init_start -> INIT, counter=0, init_busy=1.
  - init_start has priority over requests in the same cycle: no grant is given that cycle.
- INIT:
  - Each cycle: ram_en=1, ram_we=11, ram_addr=counter, ram_din=INIT_VALUE; no grants.
  - Counter increments each cycle. At counter = 2^(ADDR_MSB+1)-1 the FSM moves to DONE.
  - The fill takes exactly 2^(ADDR_MSB+1) cycles, with no wrap.
- DONE: lasts one cycle; init_done=1 and init_busy=0; arbitration is enabled; next state is IDLE.
- Requests during INIT stay pending with gnt=0. No rvalid is generated for fill writes.
- Reset in mid-fill: next cycle is IDLE with counter=0, init_busy=0, and no init_done. Memory contents are then partially filled and undefined; the bench must not check them.
- A reset in the cycle after a read grant clears the pending rvalid.

Test Plan:
- Single read: preload addr 0x010=16'hBEEF; r0 read of 0x010 -> r0_gnt same cycle, r0_rvalid=1 next cycle with rdata=16'hBEEF, r1_rvalid=0.
- Byte write: r1 writes 16'h1234 with we=11, then 16'hAB00 with we=10 to addr 0x020; r0 reads 0x020 -> rdata=16'hAB34.
- Contention: r0 and r1 hold read requests continuously from reset -> grants alternate r0,r1,r0,r1; each rvalid follows its grant by one cycle; no starvation over 20 cycles.
- Fill: ADDR_MSB=3, INIT_VALUE=16'h5A5A; pulse init_start while r0 is requesting:
  - init_busy=1 for 16 cycles, then init_done for 1 cycle;
  - r0_gnt=0 throughout the fill and 1 in the DONE cycle;
  - all 16 words read back 16'h5A5A.
- Reset mid-fill: assert puc_rst at fill cycle 5 -> next cycle init_busy=0, init_done never pulses, no grants while reset is high; after release, r0 is granted on its first request.
- Ignored restart: pulse init_start again during INIT -> exactly one init_done and 2^(ADDR_MSB+1) fill writes.
